// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO and sends each byte as an 8N1 UART frame (8E1 with UART_TX_PARITY_EN).
// Latency: tx falls on the edge after the pop cycle; frame = (2+DATA_BITS[+1])*CLKS_PER_BIT cycles.
// Backpressure: pops only from IDLE when tx_en=1 and the FIFO is non-empty; a started frame always completes.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int DATA_BITS    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_pop,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [NW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 baud_end;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      baud_end = (baud_q == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            baud_d = '0;
            // rst gates the pop so an asserted reset never consumes a byte
            if (rst && tx_en && !fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata[DATA_BITS-1:0];
               bit_d    = '0;
               state_d  = START;
`ifdef UART_TX_PARITY_EN
               parity_d = ^fifo_rdata[DATA_BITS-1:0];
`endif
            end
         end
         START: begin
            if (baud_end) begin
               state_d = DATA;
               baud_d  = '0;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               state_d = STOP;
               baud_d  = '0;
            end
         end
`endif
         STOP: begin
            if (baud_end) begin
               state_d = IDLE;
               baud_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
         end
      endcase

      // Line level is registered from the next state so tx never glitches
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO modelled as a queue, line checked against a frame-level reference.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FLEN = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_en;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_pop;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_pop   (fifo_pop),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] q[$];
   int         rem = 0;
   logic [10:0] frame;
   int         cyc = 0;
   int         dut_pops = 0;
   int         dut_pop_cyc = -1;
   int         last_gap = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty = (q.size() == 0);
      fifo_rdata = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   // Line sequence: start 0, data LSB first, optional even parity, stop 1
   function automatic logic [10:0] mk_frame(input logic [7:0] b);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      if (NBITS == 11) f[9] = ^b;
      return f;
   endfunction

   task automatic step();
      logic exp_pop;
      int   p;
      @(negedge clk);
      exp_pop = 1'b0;
      if (rem == 0) begin
         exp_pop = rst && tx_en && (q.size() != 0);
         check_eq("pop_idle", fifo_pop, exp_pop);
         check_eq("tx_idle", tx, 1'b1);
         check_eq("busy_idle", tx_busy, 1'b0);
         check_eq("done_idle", tx_done, 1'b0);
      end else begin
         p = FLEN - rem;
         check_eq("tx_frame", tx, frame[p / CPB]);
         check_eq("busy_frame", tx_busy, 1'b1);
         check_eq("done_frame", tx_done, rem == 1);
         check_eq("pop_frame", fifo_pop, 1'b0);
      end
      if (fifo_pop) begin
         dut_pops++;
         if (dut_pop_cyc >= 0) last_gap = cyc - dut_pop_cyc;
         dut_pop_cyc = cyc;
      end
      if (tx_done) check_eq("frame_len", cyc - dut_pop_cyc, FLEN);
      @(posedge clk);
      cyc++;
      if (rem > 0) rem--;
      else if (exp_pop) begin
         frame = mk_frame(q.pop_front());
         rem = FLEN;
      end
      #1;
      drive_fifo();
   endtask

   initial begin
      int n0;
      rst = 1'b0;
      tx_en = 1'b1;
      drive_fifo();
      // Reset held, then idle with empty FIFO
      repeat (3) step();
      rst = 1'b1;
      repeat (100) step();
      check_eq("idle_pops", dut_pops, 0);

      // Single byte
      q.push_back(8'hA5);
      drive_fifo();
      repeat (FLEN + 10) step();
      check_eq("single_pops", dut_pops, 1);

      // Back-to-back
      q.push_back(8'h00);
      q.push_back(8'hFF);
      drive_fifo();
      repeat (2 * FLEN + 20) step();
      check_eq("b2b_pops", dut_pops, 3);
      check_eq("b2b_gap", last_gap, FLEN + 1);

      // tx_en dropped at cycle 10 of a frame with a second byte queued
      q.push_back(8'h3C);
      q.push_back(8'hC3);
      drive_fifo();
      for (int i = 0; i < 50 && !(rem == FLEN - 10); i++) step();
      check_eq("gate_reach", rem, FLEN - 10);
      tx_en = 1'b0;
      n0 = dut_pops;
      repeat (FLEN + 30) step();
      check_eq("gate_no_pop", dut_pops, n0);
      tx_en = 1'b1;
      step();
      check_eq("gate_pop", dut_pops, n0 + 1);
      repeat (FLEN + 5) step();

      // Reset during data bit 3
      q.push_back(8'h5A);
      q.push_back(8'h96);
      drive_fifo();
      for (int i = 0; i < 50 && !(rem == FLEN - 4 * CPB); i++) step();
      check_eq("rst_reach", rem, FLEN - 4 * CPB);
      #2 rst = 1'b0;
      #1;
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_busy", tx_busy, 1'b0);
      check_eq("rst_pop", fifo_pop, 1'b0);
      rem = 0;
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      #1 rst = 1'b1;
      n0 = dut_pops;
      step();
      check_eq("rst_repop", dut_pops, n0 + 1);
      check_eq("rst_qlen", q.size(), 0);
      repeat (FLEN + 5) step();

      // Parity-relevant byte
      q.push_back(8'h07);
      drive_fifo();
      repeat (FLEN + 5) step();

      // Randomized traffic with occasional tx_en toggles
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0 && q.size() < 4) q.push_back(8'($urandom));
         if ($urandom_range(0, 299) == 0) tx_en = ~tx_en;
         drive_fifo();
         step();
      end
      tx_en = 1'b1;
      repeat (6 * (FLEN + 1)) step();
      check_eq("drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
